uart_telem_tx: RTL and testbench

//  Telemetry framer that drives the TX side of uart_core (tx_data/tx_start/tx_ready).

---
 rtl/uart_telem_tx_if.sv | 12 +
 rtl/uart_telem_tx.sv | 140 ++++++++++++++
 tb/tb_uart_telem_tx.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_telem_tx_if.sv
// Byte handshake between the telemetry framer and the UART transmitter.
//   tx_data  : byte presented to the UART (framer -> UART)
//   tx_start : 1-cycle strobe, byte is valid (framer -> UART)
//   tx_ready : UART transmitter idle and able to take a byte (UART -> framer)
interface uart_telem_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_ready;

  modport master (output tx_data, output tx_start, input tx_ready);
  modport slave  (input tx_data, input tx_start, output tx_ready);
endinterface

// File: rtl/uart_telem_tx.sv
// Telemetry framer. Snapshots NUM_CH 16-bit channels and streams one
// checksummed frame to the UART transmitter, periodically or on demand.
// Frame: 55 AA SEQ LEN ch0_hi ch0_lo .. chN-1_lo CHK, CHK = SEQ+LEN+data mod 256.
// Ports:
//   clk, reset_n   : clock, async active-low reset
//   enable         : periodic frame generation on
//   trigger        : 1-cycle request for one frame
//   ch_data        : channel k in [16k+15:16k], captured at frame start
//   tx             : byte handshake to the UART (master side)
//   busy           : frame in progress
//   frame_done     : 1-cycle pulse after the checksum byte was taken
//   seq            : sequence number of the next frame
//   overrun_cnt    : saturating count of requests dropped while busy
module uart_telem_tx #(
  parameter int CLK_FREQ_HZ = 27_000_000,
  parameter int PERIOD_HZ   = 100,
  parameter int NUM_CH      = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  trigger,
  input  logic [16*NUM_CH-1:0]  ch_data,
  uart_telem_tx_if.master       tx,
  output logic                  busy,
  output logic                  frame_done,
  output logic [7:0]            seq,
  output logic [7:0]            overrun_cnt
);
  localparam int DIV  = CLK_FREQ_HZ / PERIOD_HZ;
  localparam int CW   = $clog2(DIV);
  localparam int NB   = 2 * NUM_CH;       // data bytes per frame (= LEN)
  localparam int JW   = $clog2(NB);
  localparam int LAST = 4 + NB;           // index of the checksum byte

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEND, S_WAIT_ACK, S_WAIT_RDY, S_DONE
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_pcnt;
  logic [NB-1:0][7:0]  r_sbytes;          // shadow, stored in frame order
  logic [7:0]          r_seq_sh, r_seq, r_ovr, r_chk, r_tx_data;
  logic [4:0]          r_idx;
  logic                r_tx_start, r_busy, r_done;

  logic                w_tick, w_req;
  logic [JW-1:0]       w_j;
  logic [7:0]          w_byte;

  assign w_tick = enable && (r_pcnt == CW'(DIV - 1));
  assign w_req  = trigger || w_tick;      // coincident sources merge into one

  // Period divider: free-runs 0..DIV-1 only while enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      r_pcnt <= '0;
    else if (!enable)                  r_pcnt <= '0;
    else if (r_pcnt == CW'(DIV - 1))   r_pcnt <= '0;
    else                               r_pcnt <= r_pcnt + CW'(1);
  end

  // Byte at the current index; the checksum slot reads the running sum.
  always_comb begin
    w_j    = JW'(r_idx - 5'd4);
    w_byte = r_chk;
    case (r_idx)
      5'd0:    w_byte = 8'h55;
      5'd1:    w_byte = 8'hAA;
      5'd2:    w_byte = r_seq_sh;
      5'd3:    w_byte = 8'(NB);
      default: if (r_idx != 5'(LAST)) w_byte = r_sbytes[w_j];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_sbytes   <= '0;
      r_seq_sh   <= '0;
      r_seq      <= '0;
      r_ovr      <= '0;
      r_chk      <= '0;
      r_idx      <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_done     <= 1'b0;
      if (w_req && r_busy && r_ovr != 8'hFF) r_ovr <= r_ovr + 8'd1;
      case (r_state)
        S_IDLE: if (w_req) begin
          r_state <= S_LOAD;
          r_busy  <= 1'b1;
        end
        S_LOAD: begin
          for (int c = 0; c < NUM_CH; c++) begin
            r_sbytes[2*c]   <= ch_data[16*c+8 +: 8];
            r_sbytes[2*c+1] <= ch_data[16*c   +: 8];
          end
          r_seq_sh <= r_seq;
          r_idx    <= '0;
          r_chk    <= '0;
          r_state  <= S_SEND;
        end
        S_SEND: if (tx.tx_ready) begin
          r_tx_data  <= w_byte;
          r_tx_start <= 1'b1;
          if (r_idx >= 5'd2 && r_idx != 5'(LAST)) r_chk <= r_chk + w_byte;
          r_state    <= S_WAIT_ACK;
        end
        // UART drops ready once it has latched the byte.
        S_WAIT_ACK: if (!tx.tx_ready) r_state <= S_WAIT_RDY;
        S_WAIT_RDY: if (tx.tx_ready) begin
          if (r_idx == 5'(LAST)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_seq   <= r_seq + 8'd1;
          end else begin
            r_idx   <= r_idx + 5'd1;
            r_state <= S_SEND;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx.tx_data   = r_tx_data;
  assign tx.tx_start  = r_tx_start;
  assign busy         = r_busy;
  assign frame_done   = r_done;
  assign seq          = r_seq;
  assign overrun_cnt  = r_ovr;
endmodule

// File: tb/tb_uart_telem_tx.sv
// Bench for uart_telem_tx: a UART-side responder collects every issued byte,
// and each scenario compares the collected stream with frames built from
// the frame-format rules.
module tb_uart_telem_tx;
  localparam int NCH = 2;

  logic              clk, reset_n, enable, trigger;
  logic [16*NCH-1:0] ch_data;
  logic              busy, frame_done;
  logic [7:0]        seq, overrun_cnt;

  uart_telem_tx_if u_if();

  uart_telem_tx #(.CLK_FREQ_HZ(1_000_000), .PERIOD_HZ(1000), .NUM_CH(NCH)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .trigger(trigger),
    .ch_data(ch_data), .tx(u_if), .busy(busy), .frame_done(frame_done),
    .seq(seq), .overrun_cnt(overrun_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // UART responder: takes a byte on tx_start, stays not-ready for lat cycles,
  // and while hold=1 stays not-ready after taking a byte.
  logic       rdy, prev_st;
  int         lat, bcnt, viol, fd_cnt;
  bit         hold;
  logic [7:0] rxq[$];

  assign u_if.tx_ready = rdy;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy <= 1'b1; bcnt <= 0; prev_st <= 1'b0;
    end else begin
      prev_st <= u_if.tx_start;
      if (u_if.tx_start) begin
        if (!rdy || prev_st) viol <= viol + 1;
        rxq.push_back(u_if.tx_data);
        rdy  <= 1'b0;
        bcnt <= lat;
      end else if (bcnt != 0) bcnt <= bcnt - 1;
      else if (!hold)         rdy  <= 1'b1;
    end
  end

  always @(posedge clk) if (frame_done) fd_cnt <= fd_cnt + 1;

  // Reference frame from the format rules.
  function automatic void ref_frame(input logic [7:0] s, input logic [16*NCH-1:0] d,
                                    output logic [7:0] q[$]);
    int sum;
    q = {};
    q.push_back(8'h55); q.push_back(8'hAA); q.push_back(s); q.push_back(8'(2*NCH));
    sum = s + 2*NCH;
    for (int c = 0; c < NCH; c++) begin
      logic [15:0] w;
      w = d[16*c +: 16];
      q.push_back(w[15:8]); q.push_back(w[7:0]);
      sum = sum + w[15:8] + w[7:0];
    end
    q.push_back(8'(sum % 256));
  endfunction

  function automatic bit frame_ok(input int base, input logic [7:0] e[$]);
    if (rxq.size() != base + e.size()) return 1'b0;
    foreach (e[i]) if (rxq[base+i] !== e[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic pulse_trig();
    @(negedge clk) trigger = 1'b1;
    @(negedge clk) trigger = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (frame_done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (u_if.tx_data !== 8'h00 || u_if.tx_start !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: data=%h start=%b busy=%b done=%b, want 00 0 0 0",
               u_if.tx_data, u_if.tx_start, busy, frame_done);
    end
    tests++;
    if (seq !== 8'd0 || overrun_cnt !== 8'd0) begin
      fails++; $display("FAIL reset_counters: seq=%0d ovr=%0d, want 0 0", seq, overrun_cnt);
    end
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] e[$];
    int base, fd0; bit ok;
    e = '{8'h55, 8'hAA, 8'h00, 8'h04, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC2};
    base = rxq.size(); fd0 = fd_cnt;
    ch_data = {16'hABCD, 16'h1234};
    pulse_trig();
    @(negedge clk);
    tests++;
    if (u_if.tx_start !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL latency_load: start=%b busy=%b, want 0 1", u_if.tx_start, busy);
    end
    @(negedge clk);
    tests++;
    if (u_if.tx_start !== 1'b1 || u_if.tx_data !== 8'h55) begin
      fails++; $display("FAIL latency_first: start=%b data=%h, want 1 55", u_if.tx_start, u_if.tx_data);
    end
    wait_done(ok);
    @(negedge clk);
    tests++;
    if (!ok || !frame_ok(base, e)) begin
      fails++; $display("FAIL t1_frame: done=%b bytes=%0d last=%h, want 9 bytes ending C2",
                        ok, rxq.size() - base, rxq[rxq.size()-1]);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (fd_cnt - fd0 != 1 || seq !== 8'd1 || busy !== 1'b0) begin
      fails++; $display("FAIL t1_after: done_pulses=%0d seq=%0d busy=%b, want 1 1 0", fd_cnt - fd0, seq, busy);
    end
  endtask

  task automatic test_seq_wrap();
    logic [7:0] e[$];
    logic [16*NCH-1:0] d;
    logic [7:0] s;
    int base, bad; bit ok;
    e = '{8'h55, 8'hAA, 8'h01, 8'h04, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC3};
    base = rxq.size();
    pulse_trig(); wait_done(ok); @(negedge clk);
    tests++;
    if (!ok || !frame_ok(base, e)) begin
      fails++; $display("FAIL t2_frame: done=%b bytes=%0d last=%h, want 9 bytes ending C3",
                        ok, rxq.size() - base, rxq[rxq.size()-1]);
    end
    bad = 0;
    for (int f = 0; f < 254; f++) begin
      s = seq; d = 32'($urandom); lat = $urandom_range(0, 3);
      ch_data = d; base = rxq.size();
      ref_frame(s, d, e);
      pulse_trig(); wait_done(ok); @(negedge clk);
      if (!ok || !frame_ok(base, e)) bad++;
    end
    lat = 1;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL rand_frames: %0d bad frames, want 0", bad); end
    tests++;
    if (seq !== 8'd0) begin fails++; $display("FAIL seq_wrap: seq=%0d, want 0", seq); end
  endtask

  task automatic test_overrun();
    logic [7:0] e[$];
    logic [16*NCH-1:0] d;
    int base, ovr0; bit ok;
    d = 32'($urandom); ch_data = d; ovr0 = overrun_cnt; base = rxq.size();
    ref_frame(seq, d, e);
    pulse_trig(); pulse_trig(); pulse_trig();
    wait_done(ok); @(negedge clk);
    tests++;
    if (overrun_cnt !== 8'(ovr0 + 2)) begin
      fails++; $display("FAIL overrun_two: ovr=%0d, want %0d", overrun_cnt, ovr0 + 2);
    end
    tests++;
    if (!ok || !frame_ok(base, e)) begin
      fails++; $display("FAIL overrun_frame: done=%b bytes=%0d, want %0d", ok, rxq.size() - base, e.size());
    end
    // Stall the frame after its first byte and flood requests.
    d = 32'($urandom); ch_data = d; base = rxq.size();
    ref_frame(seq, d, e);
    hold = 1'b1;
    pulse_trig();
    @(negedge clk) trigger = 1'b1;
    repeat (300) @(negedge clk);
    trigger = 1'b0;
    tests++;
    if (overrun_cnt !== 8'hFF || busy !== 1'b1 || rxq.size() != base + 1) begin
      fails++; $display("FAIL overrun_sat: ovr=%0d busy=%b bytes=%0d, want 255 1 1",
                        overrun_cnt, busy, rxq.size() - base);
    end
    hold = 1'b0;
    wait_done(ok); @(negedge clk);
    tests++;
    if (!ok || !frame_ok(base, e)) begin
      fails++; $display("FAIL overrun_sat_frame: done=%b bytes=%0d, want %0d", ok, rxq.size() - base, e.size());
    end
  endtask

  task automatic test_stall();
    logic [7:0] e[$];
    logic [16*NCH-1:0] d;
    int base, n; bit ok;
    d = 32'($urandom); ch_data = d; base = rxq.size();
    ref_frame(seq, d, e);
    pulse_trig();
    @(negedge clk) ch_data = ~d;          // shadow already captured
    for (int i = 0; i < 500 && rxq.size() < base + 3; i++) @(negedge clk);
    hold = 1'b1;
    repeat (10) @(negedge clk);
    n = rxq.size();
    repeat (50) @(negedge clk);
    tests++;
    if (rxq.size() != n || busy !== 1'b1 || n < base + 3) begin
      fails++; $display("FAIL stall_no_start: bytes %0d->%0d busy=%b, want unchanged busy 1", n - base,
                        rxq.size() - base, busy);
    end
    hold = 1'b0;
    wait_done(ok); @(negedge clk);
    tests++;
    if (!ok || !frame_ok(base, e)) begin
      fails++; $display("FAIL stall_frame: done=%b bytes=%0d, want %0d with old data", ok, rxq.size() - base, e.size());
    end
    tests++;
    if (viol != 0) begin fails++; $display("FAIL start_protocol: %0d violations, want 0", viol); end
  endtask

  task automatic test_async_reset();
    logic [7:0] e[$];
    logic [16*NCH-1:0] d;
    int base; bit ok;
    ch_data = 32'($urandom); base = rxq.size();
    pulse_trig();
    for (int i = 0; i < 500 && rxq.size() < base + 4; i++) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (u_if.tx_data !== 8'h00 || u_if.tx_start !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 ||
        seq !== 8'd0 || overrun_cnt !== 8'd0) begin
      fails++; $display("FAIL async_reset: data=%h start=%b busy=%b done=%b seq=%0d ovr=%0d, want all 0",
                        u_if.tx_data, u_if.tx_start, busy, frame_done, seq, overrun_cnt);
    end
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(negedge clk);
    d = 32'($urandom); ch_data = d; base = rxq.size();
    ref_frame(8'h00, d, e);
    pulse_trig(); wait_done(ok); @(negedge clk);
    tests++;
    if (!ok || !frame_ok(base, e)) begin
      fails++; $display("FAIL post_reset_frame: done=%b bytes=%0d, want %0d at seq 0", ok, rxq.size() - base, e.size());
    end
  endtask

  task automatic test_periodic();
    int t[$];
    int fd0, o2;
    lat = 1;
    @(negedge clk) enable = 1'b1;
    for (int i = 1; i <= 3500; i++) begin
      @(negedge clk);
      if (frame_done) t.push_back(i);
    end
    tests++;
    if (t.size() != 3) begin fails++; $display("FAIL periodic_count: %0d frames, want 3", t.size()); end
    tests++;
    if (t.size() < 3 || t[1] - t[0] != 1000 || t[2] - t[1] != 1000) begin
      fails++; $display("FAIL periodic_interval: frames=%0d gaps=%0d,%0d, want 1000,1000",
                        t.size(), t[1] - t[0], t[2] - t[1]);
    end
    tests++;
    if (t.size() < 1 || t[0] < 1000 || t[0] > 1150) begin
      fails++; $display("FAIL periodic_first: first done at %0d, want 1000..1150", t[0]);
    end
    @(negedge clk) enable = 1'b0;
    fd0 = fd_cnt;
    repeat (2500) @(negedge clk);
    tests++;
    if (fd_cnt != fd0 || busy !== 1'b0) begin
      fails++; $display("FAIL disabled_quiet: %0d frames busy=%b, want 0 0", fd_cnt - fd0, busy);
    end
    // Divider must restart from 0, giving the same first-frame offset.
    o2 = -1;
    @(negedge clk) enable = 1'b1;
    for (int i = 1; i <= 1500; i++) begin
      @(negedge clk);
      if (frame_done) begin o2 = i; break; end
    end
    enable = 1'b0;
    tests++;
    if (t.size() < 1 || o2 != t[0]) begin
      fails++; $display("FAIL counter_held: re-enable offset %0d, want %0d", o2, t[0]);
    end
    tests++;
    if (overrun_cnt !== 8'd0) begin fails++; $display("FAIL periodic_ovr: ovr=%0d, want 0", overrun_cnt); end
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; trigger = 1'b0; ch_data = '0;
    hold = 1'b0; lat = 1;
    test_reset();
    test_basic();
    test_seq_wrap();
    test_overrun();
    test_stall();
    test_async_reset();
    test_periodic();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

  initial begin
    viol = 0; fd_cnt = 0;
  end
endmodule
